// File: rtl/lambda_requant.sv
// lambda_requant: bias add, Q-format multiply, rounding shift, zero point and clamp, then an output FIFO.
// Optional LAMBDA_REQUANT_RELU_EN raises the lower clamp bound from 0 to out_zp (fused ReLU).
module lambda_requant #(
    parameter int unsigned ACC_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned MULT_WIDTH      = 32,
    parameter int unsigned SHIFT_WIDTH     = 6,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned LOG2_FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ACC_WIDTH-1:0]       i_acc,
    input  logic                       i_acc_valid,
    input  logic [ACC_WIDTH-1:0]       i_bias,
    input  logic [MULT_WIDTH-1:0]      i_mult,
    input  logic [SHIFT_WIDTH-1:0]     i_shift,
    input  logic [DATA_WIDTH-1:0]      i_out_zp,
    input  logic                       i_cfg_valid,
    input  logic                       i_clear_err,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic                       o_idle,
    output logic                       o_overflow,
    output logic                       o_cfg_err,
    output logic [LOG2_FIFO_DEPTH:0]   o_fifo_count
);
    localparam int unsigned S1W = ACC_WIDTH + 1;
    localparam int unsigned PW  = S1W + MULT_WIDTH;
    localparam int unsigned RW  = PW + 1;
    localparam logic signed [RW:0] HI = (RW + 1)'(2 ** DATA_WIDTH - 1);
    localparam logic [LOG2_FIFO_DEPTH:0] FULL_CNT = (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH);
    localparam logic [LOG2_FIFO_DEPTH-1:0] LAST_PTR = LOG2_FIFO_DEPTH'(FIFO_DEPTH - 1);

    logic signed [ACC_WIDTH-1:0]  bias_q;
    logic signed [MULT_WIDTH-1:0] mult_q;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic [DATA_WIDTH-1:0]        zp_q;

    logic                  v1_q, v2_q, v3_q, v4_q;
    logic signed [S1W-1:0] s1_q, s1_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic signed [RW-1:0]  r_q, r_d, p_ext, rnd;
    logic signed [RW:0]    y, lo;
    logic [DATA_WIDTH-1:0] y4_q, y4_d;

    logic [DATA_WIDTH-1:0]        mem [FIFO_DEPTH];
    logic [LOG2_FIFO_DEPTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LOG2_FIFO_DEPTH:0]     count_q, count_d;
    logic                         pop, push_ok, drop, full;
    logic                         overflow_q, cfg_err_q;

    always_comb begin
        s1_d  = $signed({i_acc[ACC_WIDTH-1], i_acc}) + $signed({bias_q[ACC_WIDTH-1], bias_q});
        p_d   = PW'(s1_q) * PW'(mult_q);
        p_ext = RW'(p_q);
        rnd   = '0;
        if (shift_q != '0) begin
            rnd = $signed(RW'(1'b1) << (shift_q - SHIFT_WIDTH'(1)));
        end
        r_d = (p_ext + rnd) >>> shift_q;
        y   = (RW + 1)'(r_q) + $signed((RW + 1)'(zp_q));
`ifdef LAMBDA_REQUANT_RELU_EN
        lo = $signed((RW + 1)'(zp_q));
`else
        lo = '0;
`endif
        if (y < lo) begin
            y4_d = lo[DATA_WIDTH-1:0];
        end else if (y > HI) begin
            y4_d = HI[DATA_WIDTH-1:0];
        end else begin
            y4_d = y[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        full    = (count_q == FULL_CNT);
        pop     = (count_q != '0) && i_data_ready;
        push_ok = v4_q && (!full || pop);
        drop    = v4_q && full && !pop;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    assign o_idle       = !(v1_q || v2_q || v3_q || v4_q) && (count_q == '0);
    assign o_data_valid = (count_q != '0);
    assign o_data       = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign o_fifo_count = count_q;
    assign o_overflow   = overflow_q;
    assign o_cfg_err    = cfg_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q     <= '0;
            mult_q     <= '0;
            shift_q    <= '0;
            zp_q       <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            v4_q       <= 1'b0;
            s1_q       <= '0;
            p_q        <= '0;
            r_q        <= '0;
            y4_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (i_cfg_valid && o_idle) begin
                bias_q  <= i_bias;
                mult_q  <= i_mult;
                shift_q <= i_shift;
                zp_q    <= i_out_zp;
            end
            v1_q <= i_acc_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            s1_q <= s1_d;
            p_q  <= p_d;
            r_q  <= r_d;
            y4_q <= y4_d;
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            // A new error event outranks a simultaneous clear.
            overflow_q <= drop || (overflow_q && !i_clear_err);
            cfg_err_q  <= (i_cfg_valid && !o_idle) || (cfg_err_q && !i_clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= y4_q;
        end
    end
endmodule

// File: tb/tb_lambda_requant.sv
// Self-checking bench for lambda_requant: vector table for the arithmetic path plus
// hand-written sequences for backpressure, overflow, config guard and reset.
module tb_lambda_requant;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_acc;
    logic        i_acc_valid;
    logic [31:0] i_bias;
    logic [31:0] i_mult;
    logic [5:0]  i_shift;
    logic [7:0]  i_out_zp;
    logic        i_cfg_valid;
    logic        i_clear_err;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_idle;
    logic        o_overflow;
    logic        o_cfg_err;
    logic [2:0]  o_fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    lambda_requant dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_acc        (i_acc),
        .i_acc_valid  (i_acc_valid),
        .i_bias       (i_bias),
        .i_mult       (i_mult),
        .i_shift      (i_shift),
        .i_out_zp     (i_out_zp),
        .i_cfg_valid  (i_cfg_valid),
        .i_clear_err  (i_clear_err),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_idle       (o_idle),
        .o_overflow   (o_overflow),
        .o_cfg_err    (o_cfg_err),
        .o_fifo_count (o_fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bias;
        int mult;
        int shift;
        int zp;
        int acc;
        int exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int b, input int m, input int s, input int z);
        i_bias      = b;
        i_mult      = m;
        i_shift     = 6'(s);
        i_out_zp    = 8'(z);
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic push(input int a);
        i_acc       = a;
        i_acc_valid = 1'b1;
        tick();
        i_acc_valid = 1'b0;
    endtask

    task automatic pop_one();
        i_data_ready = 1'b1;
        tick();
        i_data_ready = 1'b0;
    endtask

    // Edges counted from the one that samples i_acc_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_data_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int exp;
        vecs[0]  = '{0, 0, 0, 0, 1234, 0};
        vecs[1]  = '{0, 1073741824, 31, 3, 100, 53};
        vecs[2]  = '{0, 1073741824, 31, 0, 3, 2};
        vecs[3]  = '{0, 1073741824, 31, 0, -3, 0};
        vecs[4]  = '{0, 1073741824, 31, 3, -3, 2};
        vecs[5]  = '{24, 1073741824, 31, 10, 1000, 255};
        vecs[6]  = '{0, 1, 0, 0, -500, 0};
        vecs[7]  = '{0, -1073741824, 31, 128, 100, 78};
        vecs[8]  = '{-5, 3, 4, 7, 13, 9};
        vecs[9]  = '{0, 1, 0, 0, 255, 255};
        vecs[10] = '{0, 1, 0, 0, 256, 255};
        vecs[11] = '{0, 1, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 1, 0, 5, 3};
        vecs[13] = '{0, 1, 1, 10, -5, 8};

        rst_n = 1'b0; i_acc = 0; i_acc_valid = 0; i_bias = 0; i_mult = 0; i_shift = 0;
        i_out_zp = 0; i_cfg_valid = 0; i_clear_err = 0; i_data_ready = 0;
        #12;
        check("rst_data", int'(o_data), 0);
        check("rst_valid", int'(o_data_valid), 0);
        check("rst_idle", int'(o_idle), 1);
        check("rst_ovf", int'(o_overflow), 0);
        check("rst_cfgerr", int'(o_cfg_err), 0);
        check("rst_count", int'(o_fifo_count), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            exp = vecs[i].exp;
`ifdef LAMBDA_REQUANT_RELU_EN
            if (exp < vecs[i].zp) exp = vecs[i].zp;
`endif
            load_cfg(vecs[i].bias, vecs[i].mult, vecs[i].shift, vecs[i].zp);
            push(vecs[i].acc);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_data", i), int'(o_data), exp);
            pop_one();
            check($sformatf("vec%0d_empty", i), int'(o_data_valid), 0);
        end

        // Overflow: six results into a four-entry FIFO with the consumer stalled.
        load_cfg(0, 1, 0, 0);
        for (int a = 10; a < 16; a++) push(a);
        repeat (5) tick();
        check("ovf_count", int'(o_fifo_count), 4);
        check("ovf_flag", int'(o_overflow), 1);
        check("ovf_idle", int'(o_idle), 0);
        i_data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_drain%0d", k), int'(o_data), 10 + k);
            tick();
        end
        i_data_ready = 1'b0;
        check("ovf_drained_valid", int'(o_data_valid), 0);
        check("ovf_drained_count", int'(o_fifo_count), 0);
        check("ovf_sticky", int'(o_overflow), 1);
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        check("ovf_cleared", int'(o_overflow), 0);

        // Full FIFO with a pop in the same cycle as the push.
        for (int a = 20; a < 24; a++) push(a);
        repeat (5) tick();
        check("full_count", int'(o_fifo_count), 4);
        push(24);
        repeat (3) tick();
        check("full_head", int'(o_data), 20);
        i_data_ready = 1'b1;
        tick();
        i_data_ready = 1'b0;
        check("full_pop_count", int'(o_fifo_count), 4);
        check("full_pop_ovf", int'(o_overflow), 0);
        i_data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("full_drain%0d", k), int'(o_data), 21 + k);
            tick();
        end
        i_data_ready = 1'b0;
        check("full_drained", int'(o_fifo_count), 0);

        // Config while busy is ignored and flagged.
        push(40);
        load_cfg(0, 1, 0, 50);
        check("cfg_err_set", int'(o_cfg_err), 1);
        wait_valid(lat);
        check("cfg_old_data0", int'(o_data), 40);
        pop_one();
        push(41);
        wait_valid(lat);
        check("cfg_old_data1", int'(o_data), 41);
        pop_one();
        push(42);
        i_clear_err = 1'b1;
        load_cfg(0, 1, 0, 60);
        i_clear_err = 1'b0;
        check("cfg_err_wins", int'(o_cfg_err), 1);
        wait_valid(lat);
        check("cfg_old_data2", int'(o_data), 42);
        pop_one();
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        check("cfg_err_clr", int'(o_cfg_err), 0);

        // Reset mid-stream flushes everything, including config.
        push(50); push(51); push(52);
        repeat (4) tick();
        push(53);
        check("pre_rst_count", int'(o_fifo_count), 3);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", int'(o_data_valid), 0);
        check("mrst_count", int'(o_fifo_count), 0);
        check("mrst_idle", int'(o_idle), 1);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_valid", int'(o_data_valid), 0);
        check("post_rst_count", int'(o_fifo_count), 0);
        push(77);
        wait_valid(lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_data", int'(o_data), 0);
        pop_one();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
